// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, types and helpers for the synchronous FIFO family
package fifo_pkg;

  localparam int DEF_DEPTH    = 32;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_AE_LEVEL = 4;
  localparam int DEF_FWFT     = 0;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DEPTH x WIDTH register array, one sync write port, one async read port
module fifo_mem_2p #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock FIFO with level flags, FWFT option, flush and sticky errors
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter int FWFT     = DEF_FWFT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          data_out,
  output logic                      lleno,
  output logic                      vacio,
  output logic                      casi_lleno,
  output logic                      casi_vacio,
  output logic [cnt_w(DEPTH)-1:0]   use_dw,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_fwft: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_fwft: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_fwft: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             rd_ok, wr_ok, wr_go, rd_go;
  fifo_err_t        err_q, err_d, err_set;

  assign rd_ok = rd_en && !vacio;
  assign wr_ok = wr_en && (!lleno || rd_ok);
  assign wr_go = wr_ok && !flush;
  assign rd_go = rd_ok && !flush;

  // Errors are suppressed during flush; a new error beats clr_err.
  always_comb begin
    err_set           = '0;
    err_set.overflow  = !flush && wr_en && !wr_ok;
    err_set.underflow = !flush && rd_en && vacio;
    err_d.overflow    = err_set.overflow  || (err_q.overflow  && !clr_err);
    err_d.underflow   = err_set.underflow || (err_q.underflow && !clr_err);
  end

  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_go) begin
        wr_ptr_d = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (rd_go) begin
        rd_ptr_d = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      case ({wr_go, rd_go})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Flags are registered from the next occupancy so they line up with use_dw.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt_q      <= '0;
      vacio      <= 1'b1;
      lleno      <= 1'b0;
      casi_vacio <= 1'b1;
      casi_lleno <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      cnt_q      <= cnt_d;
      vacio      <= (cnt_d == '0);
      lleno      <= (cnt_d == CNT_FULL);
      casi_vacio <= (cnt_d <= AE_C);
      casi_lleno <= (cnt_d >= AF_C);
      err_q      <= err_d;
    end
  end

  fifo_mem_2p #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_go),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_out = vacio ? '0 : mem_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else if (rd_go) begin
        dout_q <= mem_rdata;
      end
    end

    assign data_out = dout_q;
  end

  assign use_dw    = cnt_q;
  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb/tb_fifo_sync_fwft.sv - directed self-checking bench for fifo_sync_fwft (std and FWFT instances)
module tb_fifo_sync_fwft;

  logic clk;
  logic rst;

  logic       a_flush, a_clr, a_wr, a_rd;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [5:0] a_cnt;

  logic       b_flush, b_clr, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [2:0] b_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] bq[$];

  fifo_sync_fwft #(.DEPTH(32), .WIDTH(8), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .clr_err(a_clr), .wr_en(a_wr),
    .data_in(a_din), .rd_en(a_rd), .data_out(a_dout), .lleno(a_full),
    .vacio(a_empty), .casi_lleno(a_af), .casi_vacio(a_ae), .use_dw(a_cnt),
    .overflow(a_ov), .underflow(a_un)
  );

  fifo_sync_fwft #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .clr_err(b_clr), .wr_en(b_wr),
    .data_in(b_din), .rd_en(b_rd), .data_out(b_dout), .lleno(b_full),
    .vacio(b_empty), .casi_lleno(b_af), .casi_vacio(b_ae), .use_dw(b_cnt),
    .overflow(b_ov), .underflow(b_un)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_flush = 1'b0; a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
  endtask

  task automatic a_write(input logic [7:0] d);
    a_wr = 1'b1; a_din = d;
    cycle();
    a_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    logic       w, r;
    int         guard;

    rst = 1'b1;
    a_idle(); a_din = '0;
    b_flush = 1'b0; b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    #3 rst = 1'b0;
    cycle();
    check("rst_cnt", 32'(a_cnt), 0);
    check("rst_vacio", 32'(a_empty), 1);
    check("rst_lleno", 32'(a_full), 0);
    check("rst_casi_vacio", 32'(a_ae), 1);
    check("rst_casi_lleno", 32'(a_af), 0);
    check("rst_ov", 32'(a_ov), 0);
    check("rst_un", 32'(a_un), 0);
    check("rst_dout", 32'(a_dout), 0);
    check("rst_b_vacio", 32'(b_empty), 1);
    rst = 1'b1;
    cycle();

    for (int i = 0; i < 32; i++) begin
      a_write(8'(i));
      check("fill_cnt", 32'(a_cnt), 32'(i + 1));
      check("fill_casi_lleno", 32'(a_af), 32'(i + 1 >= 28));
      check("fill_lleno", 32'(a_full), 32'(i + 1 == 32));
      check("fill_casi_vacio", 32'(a_ae), 32'(i + 1 <= 4));
    end

    a_write(8'hEE);
    check("ovf_flag", 32'(a_ov), 1);
    check("ovf_cnt", 32'(a_cnt), 32);

    for (int i = 0; i < 32; i++) begin
      a_rd = 1'b1;
      cycle();
      check("drain_data", 32'(a_dout), 32'(i));
      check("drain_cnt", 32'(a_cnt), 32'(31 - i));
    end
    a_rd = 1'b0;
    check("drain_vacio", 32'(a_empty), 1);

    a_rd = 1'b1; cycle(); a_rd = 1'b0;
    check("unf_flag", 32'(a_un), 1);
    check("unf_cnt", 32'(a_cnt), 0);
    check("unf_dout_hold", 32'(a_dout), 32'h1F);

    a_clr = 1'b1; cycle(); a_clr = 1'b0;
    check("clr_ov", 32'(a_ov), 0);
    check("clr_un", 32'(a_un), 0);

    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h55;
    cycle(); a_idle();
    check("empty_rw_cnt", 32'(a_cnt), 1);
    check("empty_rw_un", 32'(a_un), 1);
    check("empty_rw_vacio", 32'(a_empty), 0);
    check("empty_rw_ov", 32'(a_ov), 0);
    a_clr = 1'b1; cycle(); a_clr = 1'b0;

    for (int i = 0; i < 31; i++) a_write(8'(8'h60 + i));
    check("refill_cnt", 32'(a_cnt), 32);
    check("refill_lleno", 32'(a_full), 1);

    a_write(8'hEE);
    check("ovf2_flag", 32'(a_ov), 1);
    a_wr = 1'b1; a_clr = 1'b1; a_din = 8'hEE;
    cycle(); a_idle();
    check("clr_vs_set", 32'(a_ov), 1);
    a_clr = 1'b1; cycle(); a_clr = 1'b0;
    check("clr_alone", 32'(a_ov), 0);

    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'hAB;
    cycle(); a_idle();
    check("full_rw_cnt", 32'(a_cnt), 32);
    check("full_rw_dout", 32'(a_dout), 32'h55);
    check("full_rw_ov", 32'(a_ov), 0);

    for (int i = 0; i < 32; i++) begin
      a_rd = 1'b1;
      cycle();
      check("full_rw_order", 32'(a_dout), (i < 31) ? 32'(8'h60 + i) : 32'hAB);
    end
    a_rd = 1'b0;

    for (int i = 0; i < 17; i++) a_write(8'(i));
    check("pre_flush_cnt", 32'(a_cnt), 17);
    a_flush = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h99;
    cycle(); a_idle();
    check("flush_cnt", 32'(a_cnt), 0);
    check("flush_vacio", 32'(a_empty), 1);
    check("flush_casi_vacio", 32'(a_ae), 1);
    check("flush_lleno", 32'(a_full), 0);
    check("flush_ov", 32'(a_ov), 0);
    check("flush_un", 32'(a_un), 0);
    check("flush_dout_hold", 32'(a_dout), 32'hAB);

    for (int i = 0; i < 32; i++) a_write(8'(i));
    a_write(8'hEE);
    a_flush = 1'b1; cycle(); a_flush = 1'b0;
    check("flush_keeps_ov", 32'(a_ov), 1);
    check("flush2_cnt", 32'(a_cnt), 0);
    for (int i = 0; i < 9; i++) a_write(8'(8'h30 + i));
    check("pre_rst_cnt", 32'(a_cnt), 9);
    a_rd = 1'b1; cycle(); a_rd = 1'b0;
    check("pre_rst_dout", 32'(a_dout), 32'h30);

    #3 rst = 1'b0;
    #1;
    check("mid_rst_cnt", 32'(a_cnt), 0);
    check("mid_rst_vacio", 32'(a_empty), 1);
    check("mid_rst_ov", 32'(a_ov), 0);
    check("mid_rst_casi_vacio", 32'(a_ae), 1);
    check("mid_rst_dout", 32'(a_dout), 0);
    cycle();
    rst = 1'b1;
    cycle();

    b_wr = 1'b1; b_din = 8'hA1;
    cycle(); b_wr = 1'b0;
    check("fwft_first", 32'(b_dout), 32'hA1);
    check("fwft_vacio", 32'(b_empty), 0);
    check("fwft_cnt", 32'(b_cnt), 1);
    bq.push_back(8'hA1);

    for (int k = 0; k < 40; k++) begin
      r = (k % 3 != 0) && (bq.size() > 0);
      w = (k % 4 != 3) && (bq.size() < 5 || r);
      v = 8'(8'hB0 + k);
      if (bq.size() > 0) check("fwft_head", 32'(b_dout), 32'(bq[0]));
      check("fwft_stream_cnt", 32'(b_cnt), 32'(bq.size()));
      b_wr = w; b_rd = r; b_din = v;
      cycle();
      if (r) void'(bq.pop_front());
      if (w) bq.push_back(v);
    end
    b_wr = 1'b0; b_rd = 1'b0;

    guard = 0;
    while (bq.size() > 0 && guard < 10) begin
      check("fwft_drain", 32'(b_dout), 32'(bq[0]));
      b_rd = 1'b1;
      cycle();
      void'(bq.pop_front());
      guard++;
    end
    b_rd = 1'b0;
    check("fwft_end_vacio", 32'(b_empty), 1);
    check("fwft_end_ov", 32'(b_ov), 0);
    check("fwft_end_un", 32'(b_un), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
